// File: rtl/core_pkg.sv
// Shared constants and types for the core arithmetic chain and its decoder.
package core_pkg;

  typedef logic [31:0] core_word_t;

  localparam core_word_t CORE_BASE  = 32'hDEAD_BEEF;
  localparam int         CORE_N_SUB = 19;
  localparam int         CORE_CNT_W = 16;
  // Sum of (CORE_BASE + i) for i = 1..19, modulo 2^32
  localparam core_word_t CORE_TOTAL = 32'h86E5_2C7B;

endpackage

// File: rtl/core_unwind_stage.sv
// One decoder pipeline register: subtracts a fixed constant and carries a valid bit.
module core_unwind_stage
  import core_pkg::*;
#(
  parameter core_word_t K = CORE_BASE
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  core_word_t prev_data,
  input  logic       prev_valid,
  output core_word_t data,
  output logic       valid
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data  <= '0;
      valid <= 1'b0;
    end else if (en) begin
      data  <= prev_data - K;
      valid <= prev_valid;
    end
  end

endmodule

// File: rtl/core_unwind.sv
// Decoder for the core chain: input register plus N_SUB subtract stages under one
// global enable, with a saturating count of delivered words.
module core_unwind
  import core_pkg::*;
#(
  parameter int         N_SUB = CORE_N_SUB,
  parameter core_word_t BASE  = CORE_BASE,
  parameter int         CNT_W = CORE_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [31:0]      out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] out_count
);

  logic             adv;
  core_word_t       s0_data_reg;
  logic             s0_valid_reg;
  core_word_t       stage_data  [0:N_SUB];
  logic [N_SUB:0]   stage_valid;
  logic [CNT_W-1:0] count_reg;

  // A full last slot that the sink refuses freezes the whole pipe.
  assign adv      = !stage_valid[N_SUB] | out_ready;
  assign in_ready = adv;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s0_data_reg  <= '0;
      s0_valid_reg <= 1'b0;
    end else if (adv) begin
      s0_data_reg  <= in_data;
      s0_valid_reg <= in_valid;
    end
  end

  assign stage_data[0]  = s0_data_reg;
  assign stage_valid[0] = s0_valid_reg;

  // Stage gi removes term (N_SUB+1-gi): terms come off in reverse encoder order.
  generate
    for (genvar gi = 1; gi <= N_SUB; gi++) begin : g_stage
      core_unwind_stage #(
        .K(core_word_t'(BASE + 32'(N_SUB + 1 - gi)))
      ) u_stage (
        .clk       (clk),
        .rst       (rst),
        .en        (adv),
        .prev_data (stage_data[gi-1]),
        .prev_valid(stage_valid[gi-1]),
        .data      (stage_data[gi]),
        .valid     (stage_valid[gi])
      );
    end
  endgenerate

  assign out_data  = stage_data[N_SUB];
  assign out_valid = stage_valid[N_SUB];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= '0;
    end else if (out_valid && out_ready && (count_reg != {CNT_W{1'b1}})) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign out_count = count_reg;

endmodule

// File: tb/tb_core_unwind.sv
// Directed bench for core_unwind: latency, wrap, streaming, stalls, reset and saturation.
`timescale 1ns/1ps
module tb_core_unwind;

  logic        clk;
  logic        rst;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_count;

  int n_checks = 0;
  int n_errors = 0;

  core_unwind dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_count(out_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  // Encoder chain model: adds (DEADBEEF + i) for i = 1..19.
  function automatic logic [31:0] encode(input logic [31:0] w);
    logic [31:0] acc;
    acc = w;
    for (int i = 1; i <= 19; i++) acc = acc + (32'hDEAD_BEEF + 32'(i));
    return acc;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    #1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_count", {16'd0, out_count}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
  endtask

  // One word in, measure edges from accept until out_valid.
  task automatic send_one(input logic [31:0] din, input logic [31:0] exp,
                          input logic [15:0] exp_cnt, input string tag);
    int edges;
    bit got;
    out_ready = 1'b1;
    in_data   = din;
    in_valid  = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    edges = 1;
    got = 0;
    while (edges < 40 && !got) begin
      if (out_valid) got = 1;
      else begin
        @(posedge clk); #1;
        edges++;
      end
    end
    check({tag, "_latency"}, 32'(edges), 32'd20);
    check({tag, "_data"}, out_data, exp);
    @(posedge clk); #1;
    check({tag, "_count"}, {16'd0, out_count}, {16'd0, exp_cnt});
    check({tag, "_drained"}, {31'd0, out_valid}, 32'd0);
  endtask

  // Stream n words through a scoreboard; rnd randomises in_valid and out_ready.
  task automatic run_stream(input int n, input bit rnd, input logic [15:0] exp_cnt,
                            input int exp_iters, input string tag);
    logic [31:0] exp_q[$];
    logic [31:0] orig;
    logic [31:0] held;
    int sent, dlv, iter;
    bit stalled;
    sent = 0; dlv = 0; iter = 0; stalled = 0; held = '0;
    orig = $urandom;
    while (dlv < n && iter < 3000) begin
      @(posedge clk); #1;
      if (stalled) begin
        check({tag, "_stall_valid"}, {31'd0, out_valid}, 32'd1);
        check({tag, "_stall_data"}, out_data, held);
      end
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (sent < n) begin
        in_valid = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
        in_data  = encode(orig);
      end else begin
        in_valid = 1'b0;
      end
      #1;
      check({tag, "_in_ready"}, {31'd0, in_ready}, {31'd0, (!out_valid | out_ready)});
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check({tag, "_extra_word"}, out_data, 32'hxxxx_xxxx);
        else check({tag, "_word"}, out_data, exp_q.pop_front());
        dlv++;
      end
      stalled = out_valid && !out_ready;
      held = out_data;
      if (in_valid && in_ready) begin
        exp_q.push_back(orig);
        sent++;
        orig = $urandom;
      end
      iter++;
    end
    if (iter >= 3000) check({tag, "_timeout"}, 32'(dlv), 32'(n));
    if (exp_iters != 0) check({tag, "_cycles"}, 32'(iter), 32'(exp_iters));
    @(posedge clk); #1;
    in_valid = 1'b0;
    check({tag, "_count"}, {16'd0, out_count}, {16'd0, exp_cnt});
  endtask

  initial begin
    int seen;
    rst = 1'b1;
    in_data = '0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    do_reset();

    send_one(32'h86E5_2C7B, 32'h0000_0000, 16'd1, "t1");
    send_one(32'h0000_0000, 32'h791A_D385, 16'd2, "t2");

    do_reset();
    run_stream(100, 1'b0, 16'd100, 120, "t3");
    run_stream(60, 1'b1, 16'd160, 0, "t4");

    // Ten words in flight, sink stalled so the head sits at the output.
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      in_data  = encode(32'(i));
      in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
    end
    check("t5_pre_valid", {31'd0, out_valid}, 32'd1);
    check("t5_pre_data", out_data, 32'd0);
    #1;
    rst = 1'b1;
    #1;
    check("t5_rst_valid", {31'd0, out_valid}, 32'd0);
    check("t5_rst_count", {16'd0, out_count}, 32'd0);
    check("t5_rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check("t5_no_stale", 32'(seen), 32'd0);
    send_one(encode(32'h1234_5678), 32'h1234_5678, 16'd1, "t5_new");

    force dut.count_reg = 16'hFFFE;
    #1;
    release dut.count_reg;
    #1;
    check("t6_forced", {16'd0, out_count}, 32'h0000_FFFE);
    run_stream(3, 1'b0, 16'hFFFF, 0, "t6a");
    run_stream(2, 1'b0, 16'hFFFF, 0, "t6b");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
